// File: rtl/fetch_mem_if.sv
// Memory-side handshake bundle for fetch_mem_unit.
// master: the fetch/memory unit issuing requests.
// slave: the memory answering with ack and read data.
interface fetch_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] read_data;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  read_data
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output read_data
  );
endinterface

// File: rtl/fetch_mem_unit.sv
// fetch_mem_unit: program counter, data-address register, instruction
// register with combinational decode, and a three-state memory handshake
// FSM (IDLE -> WAIT -> DONE).
// Optional feature: define FETCH_INSTR_COUNT_EN to get a 16-bit counter of
// load_ir events on instr_count; otherwise instr_count is tied to zero.
module fetch_mem_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_pc,
  input  logic        reset_pc,
  input  logic        addr_sel,
  input  logic        load_ir,
  input  logic        load_addr,
  input  logic [1:0]  mem_cmd,
  input  logic [2:0]  nsel,
  input  logic [15:0] datapath_out,
  output logic [8:0]  PC,
  fetch_mem_if.master mem,
  output logic        mem_done,
  output logic [15:0] mdata,
  output logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [1:0]  shift,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_accept;
  logic        w_complete;

  logic [8:0]  r_pc;
  logic [8:0]  r_da;
  logic [15:0] r_ir;
  logic [15:0] r_mdata;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [8:0]  r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic        r_mem_done;
  logic [8:0]  w_sel_addr;
  logic [2:0]  w_regnum;

  // Program counter: clear or increment on load_pc (9-bit wrap is natural)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= '0;
    end else if (load_pc) begin
      r_pc <= reset_pc ? '0 : r_pc + 9'd1;
    end
  end

  // Data-address register fed from the datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_da <= '0;
    end else if (load_addr) begin
      r_da <= datapath_out[8:0];
    end
  end

  // Instruction register captures the last word read from memory
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir <= '0;
    end else if (load_ir) begin
      r_ir <= r_mdata;
    end
  end

  // Address mux: instruction fetch uses PC, data access uses DA
  always_comb begin
    w_sel_addr = addr_sel ? r_pc : r_da;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state: only legal read/write commands are taken, only in IDLE
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_cmd == 2'b01 || mem_cmd == 2'b11) begin
          w_accept     = 1'b1;
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem.mem_ack) begin
          w_complete   = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Registered memory-side outputs; request fields freeze once accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_done  <= 1'b0;
    end else begin
      r_mem_done <= w_complete;
      if (w_accept) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= mem_cmd[1];
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= datapath_out;
      end else if (w_complete) begin
        r_mem_req   <= 1'b0;
      end
    end
  end

  // Read data is captured on the same edge the ack is seen; writes leave it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mdata <= '0;
    end else if (w_complete && !r_mem_we) begin
      r_mdata <= mem.read_data;
    end
  end

  // Register-number select from one-hot nsel; illegal codes give zero
  always_comb begin
    w_regnum = 3'b000;
    case (nsel)
      3'b100:  w_regnum = r_ir[10:8];
      3'b010:  w_regnum = r_ir[7:5];
      3'b001:  w_regnum = r_ir[2:0];
      default: w_regnum = 3'b000;
    endcase
  end

`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] r_instr_count;

  // Count instruction loads, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_count <= '0;
    end else if (load_ir) begin
      r_instr_count <= r_instr_count + 16'd1;
    end
  end

  assign instr_count = r_instr_count;
`else
  assign instr_count = '0;
`endif

  assign PC            = r_pc;
  assign mdata         = r_mdata;
  assign ir            = r_ir;
  assign opcode        = r_ir[15:13];
  assign op            = r_ir[12:11];
  assign shift         = r_ir[4:3];
  assign sximm8        = {{8{r_ir[7]}}, r_ir[7:0]};
  assign sximm5        = {{11{r_ir[4]}}, r_ir[4:0]};
  assign readnum       = w_regnum;
  assign writenum      = w_regnum;
  assign mem_done      = r_mem_done;
  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Directed self-checking bench for fetch_mem_unit.
module tb_fetch_mem_unit;

  logic        clk;
  logic        reset;
  logic        load_pc;
  logic        reset_pc;
  logic        addr_sel;
  logic        load_ir;
  logic        load_addr;
  logic [1:0]  mem_cmd;
  logic [2:0]  nsel;
  logic [15:0] datapath_out;
  logic [8:0]  PC;
  logic        mem_done;
  logic [15:0] mdata;
  logic [15:0] ir;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [1:0]  shift;
  logic [15:0] sximm5;
  logic [15:0] sximm8;
  logic [15:0] instr_count;

  int checks;
  int errors;

  fetch_mem_if mif ();

  fetch_mem_unit dut (
    .clk          (clk),
    .reset        (reset),
    .load_pc      (load_pc),
    .reset_pc     (reset_pc),
    .addr_sel     (addr_sel),
    .load_ir      (load_ir),
    .load_addr    (load_addr),
    .mem_cmd      (mem_cmd),
    .nsel         (nsel),
    .datapath_out (datapath_out),
    .PC           (PC),
    .mem          (mif.master),
    .mem_done     (mem_done),
    .mdata        (mdata),
    .ir           (ir),
    .opcode       (opcode),
    .op           (op),
    .readnum      (readnum),
    .writenum     (writenum),
    .shift        (shift),
    .sximm5       (sximm5),
    .sximm8       (sximm8),
    .instr_count  (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; outputs are then stable for checking
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (PC !== 9'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", PC); end
    checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mif.mem_req); end
    checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", mem_done); end
    checks++; if (mdata !== 16'h0000) begin errors++; $display("FAIL reset_mdata: got %h want 0000", mdata); end
    checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir: got %h want 0000", ir); end
    checks++; if (mif.mem_addr !== 9'd0) begin errors++; $display("FAIL reset_addr: got %h want 000", mif.mem_addr); end
    checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL reset_icount: got %0d want 0", instr_count); end
  endtask

  task automatic test_pc();
    load_pc = 1'b1;
    repeat (3) tick();
    checks++; if (PC !== 9'd3) begin errors++; $display("FAIL pc_inc3: got %0d want 3", PC); end
    reset_pc = 1'b1;
    tick();
    reset_pc = 1'b0;
    checks++; if (PC !== 9'd0) begin errors++; $display("FAIL pc_clear: got %0d want 0", PC); end
    repeat (511) tick();
    checks++; if (PC !== 9'd511) begin errors++; $display("FAIL pc_511: got %0d want 511", PC); end
    tick();
    load_pc = 1'b0;
    checks++; if (PC !== 9'd0) begin errors++; $display("FAIL pc_wrap: got %0d want 0", PC); end
    tick();
    checks++; if (PC !== 9'd0) begin errors++; $display("FAIL pc_hold: got %0d want 0", PC); end
  endtask

  task automatic test_read();
    load_pc = 1'b1;
    repeat (5) tick();
    load_pc = 1'b0;
    checks++; if (PC !== 9'd5) begin errors++; $display("FAIL read_pc5: got %0d want 5", PC); end
    addr_sel      = 1'b1;
    mif.mem_ack   = 1'b1;
    mif.read_data = 16'hD2A5;
    tick();
    checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL idle_ack_ignored: got %b want 0", mif.mem_req); end
    mem_cmd = 2'b01;
    tick();
    mem_cmd = 2'b00;
    checks++; if (mif.mem_req !== 1'b1) begin errors++; $display("FAIL read_req: got %b want 1", mif.mem_req); end
    checks++; if (mif.mem_we !== 1'b0) begin errors++; $display("FAIL read_we: got %b want 0", mif.mem_we); end
    checks++; if (mif.mem_addr !== 9'd5) begin errors++; $display("FAIL read_addr: got %0d want 5", mif.mem_addr); end
    checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL read_done_early: got %b want 0", mem_done); end
    tick();
    checks++; if (mem_done !== 1'b1) begin errors++; $display("FAIL read_done: got %b want 1", mem_done); end
    checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL read_req_drop: got %b want 0", mif.mem_req); end
    checks++; if (mdata !== 16'hD2A5) begin errors++; $display("FAIL read_mdata: got %h want d2a5", mdata); end
    tick();
    checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL read_done_pulse: got %b want 0", mem_done); end
    checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL read_no_rerequest: got %b want 0", mif.mem_req); end
    load_ir = 1'b1;
    tick();
    load_ir = 1'b0;
    nsel    = 3'b100;
    #1;
    checks++; if (ir !== 16'hD2A5) begin errors++; $display("FAIL ir_load: got %h want d2a5", ir); end
    checks++; if (opcode !== 3'b110) begin errors++; $display("FAIL opcode: got %b want 110", opcode); end
    checks++; if (op !== 2'b10) begin errors++; $display("FAIL op: got %b want 10", op); end
    checks++; if (sximm8 !== 16'hFFA5) begin errors++; $display("FAIL sximm8: got %h want ffa5", sximm8); end
    checks++; if (sximm5 !== 16'h0005) begin errors++; $display("FAIL sximm5: got %h want 0005", sximm5); end
    checks++; if (shift !== 2'b00) begin errors++; $display("FAIL shift: got %b want 00", shift); end
    checks++; if (readnum !== 3'b010) begin errors++; $display("FAIL readnum_100: got %b want 010", readnum); end
    checks++; if (writenum !== 3'b010) begin errors++; $display("FAIL writenum_100: got %b want 010", writenum); end
    nsel = 3'b010;
    #1;
    checks++; if (readnum !== 3'b101) begin errors++; $display("FAIL readnum_010: got %b want 101", readnum); end
    nsel = 3'b001;
    #1;
    checks++; if (writenum !== 3'b101) begin errors++; $display("FAIL writenum_001: got %b want 101", writenum); end
    nsel = 3'b011;
    #1;
    checks++; if (readnum !== 3'b000) begin errors++; $display("FAIL readnum_illegal: got %b want 000", readnum); end
    nsel = 3'b000;
    tick();
    checks++; if (ir !== 16'hD2A5) begin errors++; $display("FAIL ir_hold: got %h want d2a5", ir); end
  endtask

  task automatic test_write();
    mif.mem_ack   = 1'b0;
    mif.read_data = 16'h1111;
    datapath_out  = 16'h0123;
    load_addr     = 1'b1;
    tick();
    load_addr    = 1'b0;
    addr_sel     = 1'b0;
    datapath_out = 16'hBEEF;
    mem_cmd      = 2'b11;
    tick();
    mem_cmd      = 2'b00;
    datapath_out = 16'h0000;
    checks++; if (mif.mem_req !== 1'b1) begin errors++; $display("FAIL write_req: got %b want 1", mif.mem_req); end
    checks++; if (mif.mem_we !== 1'b1) begin errors++; $display("FAIL write_we: got %b want 1", mif.mem_we); end
    checks++; if (mif.mem_addr !== 9'h123) begin errors++; $display("FAIL write_addr: got %h want 123", mif.mem_addr); end
    checks++; if (mif.mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL write_wdata: got %h want beef", mif.mem_wdata); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b1 || mif.mem_addr !== 9'h123 ||
          mif.mem_wdata !== 16'hBEEF || mem_done !== 1'b0) begin
        errors++;
        $display("FAIL write_hold[%0d]: got req=%b we=%b addr=%h wdata=%h done=%b want 1 1 123 beef 0",
                 i, mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata, mem_done);
      end
    end
    mif.mem_ack = 1'b1;
    tick();
    mif.mem_ack = 1'b0;
    checks++; if (mem_done !== 1'b1) begin errors++; $display("FAIL write_done: got %b want 1", mem_done); end
    checks++; if (mdata !== 16'hD2A5) begin errors++; $display("FAIL write_mdata: got %h want d2a5", mdata); end
    tick();
    checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL write_done_pulse: got %b want 0", mem_done); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_req;
    logic [8:0] exp_done;
    exp_req       = 9'b001001001;
    exp_done      = 9'b010010010;
    addr_sel      = 1'b1;
    mif.mem_ack   = 1'b1;
    mif.read_data = 16'h0F0F;
    mem_cmd       = 2'b01;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (mif.mem_req !== exp_req[i] || mem_done !== exp_done[i]) begin
        errors++;
        $display("FAIL b2b[%0d]: got req=%b done=%b want req=%b done=%b",
                 i, mif.mem_req, mem_done, exp_req[i], exp_done[i]);
      end
    end
    mem_cmd = 2'b00;
    tick();
    tick();
    checks++; if (mdata !== 16'h0F0F) begin errors++; $display("FAIL b2b_mdata: got %h want 0f0f", mdata); end
    mem_cmd = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL illegal_cmd[%0d]: got %b want 0", i, mif.mem_req); end
    end
    mem_cmd     = 2'b00;
    mif.mem_ack = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    logic done_seen;
    done_seen     = 1'b0;
    mif.mem_ack   = 1'b0;
    mif.read_data = 16'h5A5A;
    mem_cmd       = 2'b01;
    tick();
    mem_cmd = 2'b00;
    checks++; if (mif.mem_req !== 1'b1) begin errors++; $display("FAIL rw_req: got %b want 1", mif.mem_req); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (mif.mem_req !== 1'b0) begin errors++; $display("FAIL rw_req_drop: got %b want 0", mif.mem_req); end
    checks++; if (mdata !== 16'h0000) begin errors++; $display("FAIL rw_mdata_clear: got %h want 0000", mdata); end
    mif.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_done === 1'b1) done_seen = 1'b1;
    end
    mif.mem_ack = 1'b0;
    checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL rw_no_done: got %b want 0", done_seen); end
    checks++; if (mdata !== 16'h0000) begin errors++; $display("FAIL rw_mdata: got %h want 0000", mdata); end
  endtask

  task automatic test_instr_count();
    logic [15:0] exp_cnt;
`ifdef FETCH_INSTR_COUNT_EN
    exp_cnt = 16'd5;
`else
    exp_cnt = 16'd0;
`endif
    for (int i = 0; i < 5; i++) begin
      load_ir = 1'b1;
      tick();
      load_ir = 1'b0;
      tick();
    end
    checks++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL instr_count: got %0d want %0d", instr_count, exp_cnt); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    load_pc       = 1'b0;
    reset_pc      = 1'b0;
    addr_sel      = 1'b0;
    load_ir       = 1'b0;
    load_addr     = 1'b0;
    mem_cmd       = 2'b00;
    nsel          = 3'b000;
    datapath_out  = 16'h0000;
    mif.mem_ack   = 1'b0;
    mif.read_data = 16'h0000;

    test_reset();
    test_pc();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_in_wait();
    test_instr_count();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
